// File: rtl/memory_dp.sv
// Simple-dual-port RAM with byte-lane writes, 1-cycle registered reads and a clear engine.
// Latency: read data 1 cycle after re. No backpressure; while busy (clear running) we/re are dropped.
module memory_dp #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 2**ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                RDW_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [(DATA_W+7)/8-1:0]   wbe,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rvalid,
  output logic                      busy
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DATA_W-1:0]   wmask;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rdata_d;
  logic                wr_ok;
  logic                rd_ok;

  // Expand per-byte enables to a per-bit mask; the top lane may be partial.
  for (genvar g = 0; g < DATA_W; g++) begin : g_mask
    assign wmask[g] = wbe[g/8];
  end

  assign wr_ok = we && ({1'b0, waddr} < DEPTH_X);
  assign rd_ok = {1'b0, raddr} < DEPTH_X;

  always_comb begin
    rd_word = '0;
    rdata_d = '0;
    if (rd_ok) begin
      rd_word = mem_q[raddr];
      rdata_d = rd_word;
      if (RDW_MODE != 0 && wr_ok && waddr == raddr) begin
        rdata_d = (rd_word & ~wmask) | (wdata & wmask);
      end
    end
  end

  // Array is left untouched in a reset cycle; the clear engine rewrites it afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[ptr_q] <= INIT_VAL;
      end else if (wr_ok) begin
        mem_q[waddr] <= (mem_q[waddr] & ~wmask) | (wdata & wmask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      busy_q   <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          rvalid_q <= 1'b0;
          ptr_q    <= ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_PTR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          rvalid_q <= re;
          if (re) rdata_q <= rdata_d;
          if (clr) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_memory_dp.sv
// Directed bench for memory_dp: three instances cover clear/RDW-old, 32-bit lanes/RDW-new, and a short DEPTH.
module tb_memory_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;
  logic        rv;

  // u0: 8-bit, 256 words, INIT A5, old-data read-during-write
  logic       a_rst, a_clr, a_we, a_re, a_rvalid, a_busy;
  logic [7:0] a_waddr, a_raddr, a_wdata, a_rdata;
  logic [0:0] a_wbe;
  // u1: 32-bit, 16 words, write-through read-during-write
  logic        b_rst, b_clr, b_we, b_re, b_rvalid, b_busy;
  logic [3:0]  b_waddr, b_raddr, b_wbe;
  logic [31:0] b_wdata, b_rdata;
  // u2: 8-bit, 200 words addressed with 8 bits
  logic       c_rst, c_clr, c_we, c_re, c_rvalid, c_busy;
  logic [7:0] c_waddr, c_raddr, c_wdata, c_rdata;
  logic [0:0] c_wbe;

  memory_dp #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_VAL(8'hA5), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(a_rst), .clr(a_clr), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .wbe(a_wbe), .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid), .busy(a_busy));

  memory_dp #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .INIT_VAL(32'h0), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(b_rst), .clr(b_clr), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .wbe(b_wbe), .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid), .busy(b_busy));

  memory_dp #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_VAL(8'h00), .RDW_MODE(0)) u2 (
    .clk(clk), .rst(c_rst), .clr(c_clr), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .wbe(c_wbe), .re(c_re), .raddr(c_raddr), .rdata(c_rdata), .rvalid(c_rvalid), .busy(c_busy));

  task automatic a_write(input logic [7:0] ad, input logic [7:0] d);
    a_we = 1'b1; a_waddr = ad; a_wdata = d; a_wbe = 1'b1;
    @(negedge clk);
    a_we = 1'b0;
  endtask

  task automatic a_read(input logic [7:0] ad);
    a_re = 1'b1; a_raddr = ad;
    @(negedge clk);
    rd = {24'h0, a_rdata}; rv = a_rvalid; a_re = 1'b0;
  endtask

  task automatic b_write(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
    b_we = 1'b1; b_waddr = ad; b_wdata = d; b_wbe = be;
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic b_read(input logic [3:0] ad);
    b_re = 1'b1; b_raddr = ad;
    @(negedge clk);
    rd = b_rdata; rv = b_rvalid; b_re = 1'b0;
  endtask

  task automatic c_write(input logic [7:0] ad, input logic [7:0] d);
    c_we = 1'b1; c_waddr = ad; c_wdata = d; c_wbe = 1'b1;
    @(negedge clk);
    c_we = 1'b0;
  endtask

  task automatic c_read(input logic [7:0] ad);
    c_re = 1'b1; c_raddr = ad;
    @(negedge clk);
    rd = {24'h0, c_rdata}; rv = c_rvalid; c_re = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd127; addrs[2] = 8'd255;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    checks++; if (a_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", a_rdata); end
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", a_rvalid); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", a_busy); end
    n = 0;
    while (a_busy === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    checks++; if (n != 256) begin failures++; $display("FAIL reset_clear_len got=%0d exp=256", n); end
    checks++; if (b_busy !== 1'b0 || c_busy !== 1'b0) begin
      failures++; $display("FAIL other_busy got=%b%b exp=00", b_busy, c_busy);
    end
    for (int i = 0; i < 3; i++) begin
      a_read(addrs[i]);
      checks++; if (rd !== 32'hA5 || rv !== 1'b1) begin
        failures++; $display("FAIL init_read addr=%0d got=%h/%b exp=a5/1", addrs[i], rd, rv);
      end
    end
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 8'hA5) begin
      failures++; $display("FAIL idle_hold got=%h/%b exp=a5/0", a_rdata, a_rvalid);
    end
  endtask

  task automatic test_byte_enables;
    b_write(4'd5, 32'h11223344, 4'hF);
    b_write(4'd5, 32'hAABBCCDD, 4'b0101);
    b_read(4'd5);
    checks++; if (rd !== 32'h11BB33DD || rv !== 1'b1) begin
      failures++; $display("FAIL byte_lanes got=%h/%b exp=11bb33dd/1", rd, rv);
    end
    b_write(4'd5, 32'hFFFFFFFF, 4'h0);
    b_read(4'd5);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL wbe_zero got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_rdw;
    a_write(8'd9, 8'h3C);
    a_we = 1'b1; a_waddr = 8'd9; a_wdata = 8'hF0; a_wbe = 1'b1; a_re = 1'b1; a_raddr = 8'd9;
    @(negedge clk);
    a_we = 1'b0; a_re = 1'b0;
    checks++; if (a_rdata !== 8'h3C || a_rvalid !== 1'b1) begin
      failures++; $display("FAIL rdw_old got=%h/%b exp=3c/1", a_rdata, a_rvalid);
    end
    a_read(8'd9);
    checks++; if (rd !== 32'hF0) begin failures++; $display("FAIL rdw_old_after got=%h exp=f0", rd); end
    // different addresses in one cycle
    a_we = 1'b1; a_waddr = 8'd10; a_wdata = 8'h55; a_re = 1'b1; a_raddr = 8'd9;
    @(negedge clk);
    a_we = 1'b0; a_re = 1'b0;
    checks++; if (a_rdata !== 8'hF0) begin failures++; $display("FAIL indep_read got=%h exp=f0", a_rdata); end
    a_read(8'd10);
    checks++; if (rd !== 32'h55) begin failures++; $display("FAIL indep_write got=%h exp=55", rd); end

    b_write(4'd9, 32'h3C, 4'hF);
    b_we = 1'b1; b_waddr = 4'd9; b_wdata = 32'hF0; b_wbe = 4'hF; b_re = 1'b1; b_raddr = 4'd9;
    @(negedge clk);
    b_we = 1'b0; b_re = 1'b0;
    checks++; if (b_rdata !== 32'hF0 || b_rvalid !== 1'b1) begin
      failures++; $display("FAIL rdw_new got=%h/%b exp=f0/1", b_rdata, b_rvalid);
    end
    b_read(4'd9);
    checks++; if (rd !== 32'hF0) begin failures++; $display("FAIL rdw_new_after got=%h exp=f0", rd); end
    b_we = 1'b1; b_waddr = 4'd9; b_wdata = 32'h12345678; b_wbe = 4'b1000; b_re = 1'b1; b_raddr = 4'd9;
    @(negedge clk);
    b_we = 1'b0; b_re = 1'b0;
    checks++; if (b_rdata !== 32'h120000F0) begin failures++; $display("FAIL rdw_new_lane got=%h exp=120000f0", b_rdata); end
    b_read(4'd9);
    checks++; if (rd !== 32'h120000F0) begin failures++; $display("FAIL rdw_lane_after got=%h exp=120000f0", rd); end
  endtask

  task automatic test_clear_block;
    int n, bad_v, bad_d;
    a_write(8'd3, 8'h77);
    a_read(8'd3);
    checks++; if (rd !== 32'h77) begin failures++; $display("FAIL pre_clear got=%h exp=77", rd); end
    a_clr = 1'b1; a_re = 1'b1; a_raddr = 8'd3;
    @(negedge clk);
    a_clr = 1'b0; a_re = 1'b0;
    checks++; if (a_busy !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== 8'h77) begin
      failures++; $display("FAIL clr_cycle got=%b/%b/%h exp=1/1/77", a_busy, a_rvalid, a_rdata);
    end
    n = 0; bad_v = 0; bad_d = 0;
    while (a_busy === 1'b1 && n < 1000) begin
      n++;
      a_we = (n <= 10); a_waddr = 8'd3; a_wdata = 8'h11; a_wbe = 1'b1;
      a_re = (n <= 10); a_raddr = 8'd3;
      a_clr = (n == 50);
      @(negedge clk);
      if (a_rvalid !== 1'b0) bad_v++;
      if (a_rdata !== 8'h77) bad_d++;
    end
    a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
    checks++; if (n != 256) begin failures++; $display("FAIL clr_len got=%0d exp=256", n); end
    checks++; if (bad_v != 0) begin failures++; $display("FAIL busy_rvalid got=%0d exp=0", bad_v); end
    checks++; if (bad_d != 0) begin failures++; $display("FAIL busy_rdata_hold got=%0d exp=0", bad_d); end
    a_read(8'd3);
    checks++; if (rd !== 32'hA5 || rv !== 1'b1) begin
      failures++; $display("FAIL post_clear got=%h/%b exp=a5/1", rd, rv);
    end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    repeat (99) @(negedge clk);
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", a_busy); end
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    checks++; if (a_rdata !== 8'h00 || a_rvalid !== 1'b0 || a_busy !== 1'b1) begin
      failures++; $display("FAIL mid_reset got=%h/%b/%b exp=00/0/1", a_rdata, a_rvalid, a_busy);
    end
    n = 0;
    while (a_busy === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    checks++; if (n != 256) begin failures++; $display("FAIL mid_reset_len got=%0d exp=256", n); end
    a_read(8'd0);
    checks++; if (rd !== 32'hA5) begin failures++; $display("FAIL mid_reset_read got=%h exp=a5", rd); end
  endtask

  task automatic test_out_of_range;
    c_write(8'd199, 8'h5A);
    c_write(8'd220, 8'hEE);
    c_read(8'd199);
    checks++; if (rd !== 32'h5A || rv !== 1'b1) begin failures++; $display("FAIL oor_199a got=%h/%b exp=5a/1", rd, rv); end
    c_read(8'd220);
    checks++; if (rd !== 32'h00 || rv !== 1'b1) begin failures++; $display("FAIL oor_220 got=%h/%b exp=00/1", rd, rv); end
    c_read(8'd199);
    checks++; if (rd !== 32'h5A) begin failures++; $display("FAIL oor_199b got=%h exp=5a", rd); end
  endtask

  initial begin
    a_rst = 0; a_clr = 0; a_we = 0; a_re = 0; a_waddr = 0; a_raddr = 0; a_wdata = 0; a_wbe = 0;
    b_rst = 0; b_clr = 0; b_we = 0; b_re = 0; b_waddr = 0; b_raddr = 0; b_wdata = 0; b_wbe = 0;
    c_rst = 0; c_clr = 0; c_we = 0; c_re = 0; c_waddr = 0; c_raddr = 0; c_wdata = 0; c_wbe = 0;
    @(negedge clk);
    test_reset();
    test_byte_enables();
    test_rdw();
    test_clear_block();
    test_reset_mid_clear();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
